// File: rtl/fsab_arb_sched_pkg.sv
// Shared types for the FSAB round-robin scheduler: request field widths,
// FSM state encodings, the request bundle struct and a pointer wrap helper.
package fsab_arb_sched_pkg;

    localparam int REQ_HI  = 0;
    localparam int DID_HI  = 3;
    localparam int ADDR_HI = 30;
    localparam int LEN_HI  = 2;
    localparam int DATA_HI = 63;
    localparam int MASK_HI = 7;

    typedef enum logic [1:0] {
        FSAB_ARB_ST_IDLE  = 2'd0,
        FSAB_ARB_ST_START = 2'd1,
        FSAB_ARB_ST_BUSY  = 2'd2
    } fsab_arb_st_e;

    typedef struct packed {
        logic [REQ_HI:0]  mode;
        logic [DID_HI:0]  did;
        logic [DID_HI:0]  subdid;
        logic [ADDR_HI:0] addr;
        logic [LEN_HI:0]  len;
        logic [DATA_HI:0] data;
        logic [MASK_HI:0] mask;
    } fsab_req_t;

    // Next port after v, wrapping to 0 past the last of n ports.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/fsab_arb_sched_if.sv
// Bus between the per-master arbiter FIFOs (slave side) and the scheduler
// (master side), including the muxed downstream FSAB request.
interface fsab_arb_sched_if
    import fsab_arb_sched_pkg::*;
#(
    parameter int NUM_PORTS = 4
);

    logic [NUM_PORTS-1:0]             fifo_empty_b;
    logic [NUM_PORTS-1:0]             fifo_active;
    logic [NUM_PORTS-1:0]             fifo_start;
    logic [NUM_PORTS-1:0]             fifo_valid;
    logic [NUM_PORTS*(REQ_HI+1)-1:0]  fifo_mode;
    logic [NUM_PORTS*(DID_HI+1)-1:0]  fifo_did;
    logic [NUM_PORTS*(DID_HI+1)-1:0]  fifo_subdid;
    logic [NUM_PORTS*(ADDR_HI+1)-1:0] fifo_addr;
    logic [NUM_PORTS*(LEN_HI+1)-1:0]  fifo_len;
    logic [NUM_PORTS*(DATA_HI+1)-1:0] fifo_data;
    logic [NUM_PORTS*(MASK_HI+1)-1:0] fifo_mask;

    logic             fsabo_valid;
    logic [REQ_HI:0]  fsabo_mode;
    logic [DID_HI:0]  fsabo_did;
    logic [DID_HI:0]  fsabo_subdid;
    logic [ADDR_HI:0] fsabo_addr;
    logic [LEN_HI:0]  fsabo_len;
    logic [DATA_HI:0] fsabo_data;
    logic [MASK_HI:0] fsabo_mask;

    modport master (
        input  fifo_empty_b, fifo_active, fifo_valid, fifo_mode, fifo_did,
               fifo_subdid, fifo_addr, fifo_len, fifo_data, fifo_mask,
        output fifo_start, fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid,
               fsabo_addr, fsabo_len, fsabo_data, fsabo_mask
    );

    modport slave (
        output fifo_empty_b, fifo_active, fifo_valid, fifo_mode, fifo_did,
               fifo_subdid, fifo_addr, fifo_len, fifo_data, fifo_mask,
        input  fifo_start, fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid,
               fsabo_addr, fsabo_len, fsabo_data, fsabo_mask
    );

endinterface

// File: rtl/fsab_rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping.
// The request vector is doubled so the wrap becomes a plain upward search.
module fsab_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_HI    = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_HI:0]      ptr,
    output logic                 any,
    output logic [IDX_HI:0]      idx
);

    localparam int IW = IDX_HI + 1;

    logic [2*NUM_PORTS-1:0] dbl;

    assign dbl = {req, req};
    assign any = |req;

    // Scanning downward lets the lowest qualifying position win without a found flag.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        idx = '0;
        for (int i = 2*NUM_PORTS - 1; i >= 0; i--) begin
            if (i >= int'(ptr) && dbl[i]) idx = IW'(i % NUM_PORTS);
        end
    end

endmodule

// File: rtl/fsab_arb_sched.sv
// Round-robin scheduler granting one per-master FSAB FIFO at a time onto the
// shared downstream request bus, with a sticky stall detector.
module fsab_arb_sched
    import fsab_arb_sched_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_HI    = 1,
    parameter int STALL_MAX = 1023
) (
    input  logic                  clk,
    input  logic                  rst_b,
    fsab_arb_sched_if.master      bus,
    output logic [IDX_HI:0]       grant_idx,
    output logic                  busy,
    output logic                  stall_err
);

    localparam int          IW        = IDX_HI + 1;
    localparam logic [9:0]  STALL_LIM = 10'(STALL_MAX);

    fsab_arb_st_e          state_q, state_d;
    logic [IDX_HI:0]       grant_q, grant_d;
    logic [IDX_HI:0]       ptr_q, ptr_d, ptr_next;
    logic [IDX_HI:0]       pick_idx;
    logic                  pick_any;
    logic [9:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [NUM_PORTS-1:0]  start_vec;
    fsab_req_t             sel;

    fsab_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_HI    (IDX_HI)
    ) u_pick (
        .req (bus.fifo_empty_b),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign ptr_next = IW'(wrap_inc(int'(grant_q), NUM_PORTS));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        start_vec = '0;
        case (state_q)
            FSAB_ARB_ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = FSAB_ARB_ST_START;
                end
            end
            FSAB_ARB_ST_START: begin
                start_vec = NUM_PORTS'(1) << grant_q;
                cnt_d     = '0;
                state_d   = FSAB_ARB_ST_BUSY;
            end
            FSAB_ARB_ST_BUSY: begin
                // Timeout wins over a coincident active drop so the error is never missed.
                if (cnt_q == STALL_LIM) begin
                    err_d   = 1'b1;
                    state_d = FSAB_ARB_ST_IDLE;
                    ptr_d   = ptr_next;
                end else if (!bus.fifo_active[grant_q]) begin
                    state_d = FSAB_ARB_ST_IDLE;
                    ptr_d   = ptr_next;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = FSAB_ARB_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= FSAB_ARB_ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        int gi;
        gi         = int'(grant_q);
        sel.mode   = bus.fifo_mode  [gi*(REQ_HI+1)  +: REQ_HI+1];
        sel.did    = bus.fifo_did   [gi*(DID_HI+1)  +: DID_HI+1];
        sel.subdid = bus.fifo_subdid[gi*(DID_HI+1)  +: DID_HI+1];
        sel.addr   = bus.fifo_addr  [gi*(ADDR_HI+1) +: ADDR_HI+1];
        sel.len    = bus.fifo_len   [gi*(LEN_HI+1)  +: LEN_HI+1];
        sel.data   = bus.fifo_data  [gi*(DATA_HI+1) +: DATA_HI+1];
        sel.mask   = bus.fifo_mask  [gi*(MASK_HI+1) +: MASK_HI+1];
    end

    assign bus.fifo_start   = start_vec;
    assign bus.fsabo_valid  = bus.fifo_valid[grant_q] & (state_q != FSAB_ARB_ST_IDLE);
    assign bus.fsabo_mode   = sel.mode;
    assign bus.fsabo_did    = sel.did;
    assign bus.fsabo_subdid = sel.subdid;
    assign bus.fsabo_addr   = sel.addr;
    assign bus.fsabo_len    = sel.len;
    assign bus.fsabo_data   = sel.data;
    assign bus.fsabo_mask   = sel.mask;

    assign grant_idx = grant_q;
    assign busy      = (state_q != FSAB_ARB_ST_IDLE);
    assign stall_err = err_q;

    // Out_valid from a port that does not hold the grant is dropped by the mux; flag it.
    always_ff @(posedge clk) begin
        if (rst_b && state_q != FSAB_ARB_ST_IDLE) begin
            assert ((bus.fifo_valid & ~(NUM_PORTS'(1) << grant_q)) == '0)
                else $warning("fsab_arb_sched: out_valid from ungranted port ignored");
        end
    end

endmodule
